if_pc_gen: RTL and testbench



---
 rtl/if_pc_gen_if.sv | 27 ++
 rtl/if_pc_gen.sv | 103 ++++++++++
 tb/tb_if_pc_gen.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/if_pc_gen_if.sv
// Fetch-side bundle between the ID-stage redirect sources and the PC generator.
// master drives the ID-stage controls and observes the fetch outputs; slave is the generator.
interface if_pc_gen_if;
    logic        Nop;
    logic        BrTaken;
    logic        Jump;
    logic        JrSel;
    logic [31:0] IdPC;
    logic [15:0] Imm16;
    logic [25:0] jumpstr;
    logic [31:0] jrAddr;
    logic [31:0] PC;
    logic [31:0] PC_plus4;
    logic        IF_Flush;
    logic        RedirPend;
    logic        AdErr;

    modport master (
        output Nop, BrTaken, Jump, JrSel, IdPC, Imm16, jumpstr, jrAddr,
        input  PC, PC_plus4, IF_Flush, RedirPend, AdErr
    );

    modport slave (
        input  Nop, BrTaken, Jump, JrSel, IdPC, Imm16, jumpstr, jrAddr,
        output PC, PC_plus4, IF_Flush, RedirPend, AdErr
    );
endinterface

// File: rtl/if_pc_gen.sv
// Fetch-stage PC generator: sequential/branch/jump/jr next-PC, stall hold and IF/ID squash.
// Optional misaligned-target trap to EXC_PC enabled by defining PCGEN_ALIGN_CHK_EN.
//
// state   | meaning
// ST_RUN  | normal fetch, no redirect outstanding
// ST_HOLD | redirect captured during a stall, applied when Nop drops
module if_pc_gen #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_PC   = 32'h0000_4180
) (
    input logic         Clk,
    input logic         ReSet_n,
    if_pc_gen_if.slave  bus
);

    typedef enum logic {ST_RUN, ST_HOLD} state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] pend_q;
    logic [31:0] br_tgt;
    logic [31:0] jmp_tgt;
    logic [31:0] live_tgt;
    logic [31:0] load_raw;
    logic [31:0] load_tgt;
    logic        req;
    logic        redir;
    logic        misalign;

    assign req     = bus.JrSel | bus.Jump | bus.BrTaken;
    assign br_tgt  = bus.IdPC + {{14{bus.Imm16[15]}}, bus.Imm16, 2'b00};
    assign jmp_tgt = {bus.IdPC[31:28], bus.jumpstr, 2'b00};

    always_comb begin
        live_tgt = br_tgt;
        if (bus.Jump)  live_tgt = jmp_tgt;
        if (bus.JrSel) live_tgt = bus.jrAddr;
    end

    // A live request always beats the held one; the held target is used only on a quiet release.
    assign redir    = req | (state_q == ST_HOLD);
    assign load_raw = req ? live_tgt : pend_q;

`ifdef PCGEN_ALIGN_CHK_EN
    logic aderr_q;

    assign misalign = |load_raw[1:0];
    assign load_tgt = misalign ? EXC_PC : load_raw;
    assign bus.AdErr = aderr_q;

    always_ff @(posedge Clk) begin
        if (!ReSet_n)
            aderr_q <= 1'b0;
        else
            aderr_q <= ~bus.Nop & redir & misalign;
    end
`else
    logic unused_align;

    assign misalign     = 1'b0;
    assign load_tgt     = load_raw;
    assign bus.AdErr    = 1'b0;
    assign unused_align = misalign ^ (^EXC_PC);
`endif

    assign bus.PC        = pc_q;
    assign bus.PC_plus4  = pc_q + 32'd4;
    assign bus.RedirPend = (state_q == ST_HOLD);
    assign bus.IF_Flush  = ReSet_n & ~bus.Nop & redir;

    always_ff @(posedge Clk) begin
        if (!ReSet_n) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            pend_q  <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (bus.Nop) begin
                        if (req) begin
                            pend_q  <= live_tgt;
                            state_q <= ST_HOLD;
                        end
                    end else if (req) begin
                        pc_q <= load_tgt;
                    end else begin
                        pc_q <= pc_q + 32'd4;
                    end
                end
                ST_HOLD: begin
                    if (bus.Nop) begin
                        if (req) pend_q <= live_tgt;
                    end else begin
                        pc_q    <= load_tgt;
                        state_q <= ST_RUN;
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_if_pc_gen.sv
// Self-checking bench for if_pc_gen: directed plan steps followed by randomized traffic
// compared against a behavioural fetch model.
module tb_if_pc_gen;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_PC = 32'h0000_4180;

    logic Clk;
    logic ReSet_n;
    int   checks;
    int   errors;

    if_pc_gen_if bus ();

    if_pc_gen #(.RESET_PC(RST_PC), .EXC_PC(EXC_PC)) dut (
        .Clk     (Clk),
        .ReSet_n (ReSet_n),
        .bus     (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // behavioural model: fetch address, optional held redirect, address-error flag
    logic [31:0] m_pc;
    bit          m_pend_v;
    logic [31:0] m_pend;
    bit          m_aderr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_target();
        int off;
        if (bus.JrSel) return bus.jrAddr;
        if (bus.Jump)  return (bus.IdPC & 32'hF000_0000) | (32'(bus.jumpstr) * 4);
        off = $signed(bus.Imm16);
        return bus.IdPC + 32'(off * 4);
    endfunction

    task automatic model_load(input logic [31:0] t);
`ifdef PCGEN_ALIGN_CHK_EN
        if (t % 4 != 0) begin
            m_pc    = EXC_PC;
            m_aderr = 1;
        end else begin
            m_pc = t;
        end
`else
        m_pc = t;
`endif
    endtask

    task automatic model_reset();
        m_pc     = RST_PC;
        m_pend_v = 0;
        m_pend   = '0;
        m_aderr  = 0;
    endtask

    task automatic set_in(input bit nop, input bit br, input bit j, input bit jr,
                          input logic [31:0] idpc, input logic [15:0] imm,
                          input logic [25:0] js, input logic [31:0] jra);
        bus.Nop     = nop;
        bus.BrTaken = br;
        bus.Jump    = j;
        bus.JrSel   = jr;
        bus.IdPC    = idpc;
        bus.Imm16   = imm;
        bus.jumpstr = js;
        bus.jrAddr  = jra;
    endtask

    // Inputs are already driven (at the falling edge); check, clock once, advance the model.
    task automatic cycle();
        bit          req;
        bit          flush;
        logic [31:0] live;
        #1;
        req   = bus.JrSel || bus.Jump || bus.BrTaken;
        live  = model_target();
        flush = ReSet_n && !bus.Nop && (req || m_pend_v);
        chk("pc",        bus.PC,        m_pc);
        chk("pc_plus4",  bus.PC_plus4,  m_pc + 32'd4);
        chk("if_flush",  32'(bus.IF_Flush),  32'(flush));
        chk("redirpend", 32'(bus.RedirPend), 32'(m_pend_v));
        chk("aderr",     32'(bus.AdErr),     32'(m_aderr));
        @(posedge Clk);
        if (!ReSet_n) begin
            model_reset();
        end else begin
            m_aderr = 0;
            if (bus.Nop) begin
                if (req) begin
                    m_pend_v = 1;
                    m_pend   = live;
                end
            end else begin
                if (req)           model_load(live);
                else if (m_pend_v) model_load(m_pend);
                else               m_pc = m_pc + 32'd4;
                m_pend_v = 0;
            end
        end
        @(negedge Clk);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        ReSet_n = 1'b0;
        set_in(0, 0, 0, 0, '0, '0, '0, '0);
        @(negedge Clk);
        model_reset();

        // second reset cycle with a request present: flush must stay low
        set_in(0, 1, 0, 0, 32'h3008, 16'hFFFE, '0, '0);
        cycle();
        ReSet_n = 1'b1;
        set_in(0, 0, 0, 0, '0, '0, '0, '0);
        chk("rst_pc", bus.PC, 32'h3000);
        chk("rst_pend", 32'(bus.RedirPend), 32'd0);
        cycle();
        chk("seq_3004", bus.PC, 32'h3004);
        cycle();
        chk("seq_3008", bus.PC, 32'h3008);

        // taken branch back by two words
        set_in(0, 1, 0, 0, 32'h3008, 16'hFFFE, '0, '0);
        #1 chk("br_flush", 32'(bus.IF_Flush), 32'd1);
        cycle();
        chk("br_pc", bus.PC, 32'h3000);

        // jr beats j, then j alone
        set_in(0, 0, 1, 1, 32'h3010, '0, 26'h0000100, 32'h0000_5000);
        cycle();
        chk("jr_prio", bus.PC, 32'h5000);
        set_in(0, 0, 1, 0, 32'h3010, '0, 26'h0000100, 32'h0000_5000);
        cycle();
        chk("j_pc", bus.PC, 32'h0000_0400);

        // redirect during stall, held for three idle stall cycles
        set_in(1, 0, 1, 0, 32'h3010, '0, 26'h40, '0);
        #1 chk("stall_noflush", 32'(bus.IF_Flush), 32'd0);
        cycle();
        chk("hold_pend", 32'(bus.RedirPend), 32'd1);
        chk("hold_pc", bus.PC, 32'h0000_0400);
        set_in(1, 0, 0, 0, '0, '0, '0, '0);
        repeat (3) cycle();
        set_in(0, 0, 0, 0, '0, '0, '0, '0);
        #1 chk("release_flush", 32'(bus.IF_Flush), 32'd1);
        cycle();
        chk("release_pc", bus.PC, 32'h0000_0100);
        chk("release_pend", 32'(bus.RedirPend), 32'd0);

        // newest held redirect wins
        set_in(1, 0, 1, 0, 32'h3010, '0, 26'h40, '0);
        cycle();
        set_in(1, 0, 0, 1, '0, '0, '0, 32'h0000_6000);
        cycle();
        set_in(0, 0, 0, 0, '0, '0, '0, '0);
        cycle();
        chk("overwrite_pc", bus.PC, 32'h0000_6000);

        // reset while holding
        set_in(1, 0, 1, 0, 32'h3010, '0, 26'h40, '0);
        cycle();
        ReSet_n = 1'b0;
        cycle();
        ReSet_n = 1'b1;
        set_in(0, 0, 0, 0, '0, '0, '0, '0);
        chk("hold_rst_pc", bus.PC, 32'h3000);
        chk("hold_rst_pend", 32'(bus.RedirPend), 32'd0);
        cycle();

        // wrap-around
        set_in(0, 0, 0, 1, '0, '0, '0, 32'hFFFF_FFFC);
        cycle();
        set_in(0, 0, 0, 0, '0, '0, '0, '0);
        #1 chk("wrap_plus4", bus.PC_plus4, 32'h0);
        cycle();
        chk("wrap_pc", bus.PC, 32'h0);

        // misaligned jr target
        set_in(0, 0, 0, 1, '0, '0, '0, 32'h0000_5002);
        cycle();
`ifdef PCGEN_ALIGN_CHK_EN
        chk("align_pc", bus.PC, EXC_PC);
        chk("align_aderr", 32'(bus.AdErr), 32'd1);
`else
        chk("align_pc", bus.PC, 32'h0000_5002);
        chk("align_aderr", 32'(bus.AdErr), 32'd0);
`endif
        set_in(0, 0, 0, 0, '0, '0, '0, '0);
        cycle();
        chk("aderr_clear", 32'(bus.AdErr), 32'd0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] jra;
            ReSet_n = ($urandom_range(0, 49) != 0);
            jra = $urandom;
            if ($urandom_range(0, 3) != 0) jra[1:0] = 2'b00;
            set_in($urandom_range(0, 2) == 0,
                   $urandom_range(0, 4) == 0,
                   $urandom_range(0, 5) == 0,
                   $urandom_range(0, 6) == 0,
                   {$urandom} & 32'hFFFF_FFFC,
                   16'($urandom),
                   26'($urandom),
                   jra);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
